// File: rtl/iob_eth_arb_pkg.sv
// Shared encodings for the CPU/ethmac memory arbiter: FSM states, one-hot
// grant values and the watchdog terminal count.
package iob_eth_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_ETH  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_ETH  = 2'b10;

    // Watchdog terminal count: all ones for a counter of the given width.
    function automatic logic [31:0] wdog_tc(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/iob_eth_mem_arb.sv
// Round-robin arbiter sharing one memory port between the CPU native bus
// and the ethmac Wishbone DMA master, with a watchdog on stalled accesses.
//
// state   | meaning
// IDLE    | no owner; sample CPU/ETH requests and grant
// CPU     | CPU owns memory; wait for mem_ready or watchdog
// ETH     | ETH DMA owns memory; wait for mem_ready or watchdog
// RESP    | one-cycle ready/ack/err pulse, then back to IDLE
module iob_eth_mem_arb
    import iob_eth_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_valid,
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    input  logic [31:0]         eth_wb_adr_i,
    input  logic [DATA_W/8-1:0] eth_wb_sel_i,
    input  logic                eth_wb_we_i,
    input  logic [DATA_W-1:0]   eth_wb_dat_i,
    output logic [DATA_W-1:0]   eth_wb_dat_o,
    input  logic                eth_wb_cyc_i,
    input  logic                eth_wb_stb_i,
    output logic                eth_wb_ack_o,
    output logic                eth_wb_err_o,
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic [1:0]          gnt_o
);

    localparam logic [TIMEOUT_W-1:0] WDOG_TC = TIMEOUT_W'(wdog_tc(TIMEOUT_W));

    arb_state_t           state;
    logic [1:0]           last_gnt;
    logic [TIMEOUT_W-1:0] wdog;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic                 eth_abort;
    logic                 cpu_req;
    logic                 eth_req;
    logic                 cpu_wins;
    logic                 done;
    logic                 unused_adr_hi;

    assign cpu_req       = cpu_valid;
    assign eth_req       = eth_wb_cyc_i & eth_wb_stb_i;
    assign cpu_wins      = cpu_req & (~eth_req | (last_gnt == GNT_ETH));
    assign wdog_inc      = wdog + 1'b1;
    assign done          = mem_ready | (wdog_inc == WDOG_TC);
    assign unused_adr_hi = ^eth_wb_adr_i[31:ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            last_gnt     <= GNT_ETH;
            wdog         <= '0;
            eth_abort    <= 1'b0;
            cpu_rdata    <= '0;
            cpu_ready    <= 1'b0;
            eth_wb_dat_o <= '0;
            eth_wb_ack_o <= 1'b0;
            eth_wb_err_o <= 1'b0;
            mem_valid    <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            gnt_o        <= GNT_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_wins) begin
                        state       <= ST_CPU;
                        last_gnt    <= GNT_CPU;
                        gnt_o       <= GNT_CPU;
                        mem_valid   <= 1'b1;
                        mem_address <= cpu_address;
                        mem_wdata   <= cpu_wdata;
                        mem_wstrb   <= cpu_wstrb;
                        wdog        <= '0;
                    end else if (eth_req) begin
                        state       <= ST_ETH;
                        last_gnt    <= GNT_ETH;
                        gnt_o       <= GNT_ETH;
                        mem_valid   <= 1'b1;
                        mem_address <= eth_wb_adr_i[ADDR_W-1:0];
                        mem_wdata   <= eth_wb_dat_i;
                        mem_wstrb   <= eth_wb_we_i ? eth_wb_sel_i : '0;
                        wdog        <= '0;
                        eth_abort   <= 1'b0;
                    end
                end
                ST_CPU, ST_ETH: begin
                    if (state == ST_ETH && !eth_wb_stb_i) begin
                        eth_abort <= 1'b1;
                    end
                    if (done) begin
                        state     <= ST_RESP;
                        mem_valid <= 1'b0;
                        gnt_o     <= GNT_NONE;
                        if (state == ST_CPU) begin
                            cpu_ready <= 1'b1;
                            cpu_rdata <= mem_ready ? mem_rdata : '0;
                        end else if (eth_wb_stb_i && !eth_abort) begin
                            // A master that withdrew its strobe gets no response.
                            if (mem_ready) begin
                                eth_wb_ack_o <= 1'b1;
                                eth_wb_dat_o <= mem_rdata;
                            end else begin
                                eth_wb_err_o <= 1'b1;
                            end
                        end
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    cpu_ready    <= 1'b0;
                    eth_wb_ack_o <= 1'b0;
                    eth_wb_err_o <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_mem_arb.sv
// Directed self-checking bench for iob_eth_mem_arb (watchdog width 4).
module tb_iob_eth_mem_arb;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT_W = 4;

    logic              clk;
    logic              rst;
    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_address;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wstrb;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic [31:0]       eth_wb_adr_i;
    logic [3:0]        eth_wb_sel_i;
    logic              eth_wb_we_i;
    logic [31:0]       eth_wb_dat_i;
    logic [31:0]       eth_wb_dat_o;
    logic              eth_wb_cyc_i;
    logic              eth_wb_stb_i;
    logic              eth_wb_ack_o;
    logic              eth_wb_err_o;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [1:0]        gnt_o;

    int checks   = 0;
    int failures = 0;

    iob_eth_mem_arb #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_valid    (cpu_valid),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_wstrb    (cpu_wstrb),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .eth_wb_adr_i (eth_wb_adr_i),
        .eth_wb_sel_i (eth_wb_sel_i),
        .eth_wb_we_i  (eth_wb_we_i),
        .eth_wb_dat_i (eth_wb_dat_i),
        .eth_wb_dat_o (eth_wb_dat_o),
        .eth_wb_cyc_i (eth_wb_cyc_i),
        .eth_wb_stb_i (eth_wb_stb_i),
        .eth_wb_ack_o (eth_wb_ack_o),
        .eth_wb_err_o (eth_wb_err_o),
        .mem_valid    (mem_valid),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .gnt_o        (gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    logic [1:0] exp_gnt [3];
    int         mv_cycles;

    initial begin
        rst          = 1'b0;
        cpu_valid    = 1'b0;
        cpu_address  = '0;
        cpu_wdata    = '0;
        cpu_wstrb    = '0;
        eth_wb_adr_i = '0;
        eth_wb_sel_i = '0;
        eth_wb_we_i  = 1'b0;
        eth_wb_dat_i = '0;
        eth_wb_cyc_i = 1'b0;
        eth_wb_stb_i = 1'b0;
        mem_rdata    = '0;
        mem_ready    = 1'b0;
        exp_gnt[0]   = 2'b01;
        exp_gnt[1]   = 2'b10;
        exp_gnt[2]   = 2'b01;

        tick();
        tick();
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_ack_err", {eth_wb_ack_o, eth_wb_err_o}, 0);
        chk("rst_mem_address", mem_address, 0);
        rst = 1'b1;
        tick();

        // CPU read of 0x0040 answered in the first access cycle
        cpu_valid   = 1'b1;
        cpu_address = 16'h0040;
        cpu_wstrb   = 4'h0;
        tick();
        chk("cpu_rd_gnt", gnt_o, 2'b01);
        chk("cpu_rd_valid", mem_valid, 1);
        chk("cpu_rd_addr", mem_address, 16'h0040);
        chk("cpu_rd_wstrb", mem_wstrb, 0);
        chk("cpu_rd_no_ready_yet", cpu_ready, 0);
        cpu_valid = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("cpu_rd_ready", cpu_ready, 1);
        chk("cpu_rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("cpu_rd_resp_gnt", gnt_o, 0);
        chk("cpu_rd_resp_valid", mem_valid, 0);
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        tick();
        chk("cpu_rd_ready_pulse", cpu_ready, 0);
        chk("cpu_rd_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

        // ETH write with one wait cycle
        eth_wb_adr_i = 32'h0000_1234;
        eth_wb_sel_i = 4'hC;
        eth_wb_we_i  = 1'b1;
        eth_wb_dat_i = 32'hA5A5_0000;
        eth_wb_cyc_i = 1'b1;
        eth_wb_stb_i = 1'b1;
        tick();
        chk("eth_wr_gnt", gnt_o, 2'b10);
        chk("eth_wr_addr", mem_address, 16'h1234);
        chk("eth_wr_wstrb", mem_wstrb, 4'hC);
        chk("eth_wr_wdata", mem_wdata, 32'hA5A5_0000);
        tick();
        chk("eth_wr_wait_valid", mem_valid, 1);
        chk("eth_wr_wait_ack", eth_wb_ack_o, 0);
        mem_ready = 1'b1;
        tick();
        chk("eth_wr_ack", eth_wb_ack_o, 1);
        chk("eth_wr_err", eth_wb_err_o, 0);
        mem_ready    = 1'b0;
        eth_wb_cyc_i = 1'b0;
        eth_wb_stb_i = 1'b0;
        eth_wb_we_i  = 1'b0;
        tick();
        chk("eth_wr_ack_pulse", eth_wb_ack_o, 0);

        // Three simultaneous requests: round-robin CPU, ETH, CPU
        cpu_valid    = 1'b1;
        cpu_address  = 16'h0100;
        eth_wb_adr_i = 32'h0000_0200;
        eth_wb_cyc_i = 1'b1;
        eth_wb_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rr_gnt_%0d", i), gnt_o, exp_gnt[i]);
            chk($sformatf("rr_addr_%0d", i), mem_address,
                (exp_gnt[i] == 2'b01) ? 16'h0100 : 16'h0200);
            mem_ready = 1'b1;
            mem_rdata = 32'h1000 + i;
            tick();
            chk($sformatf("rr_resp_%0d", i), {cpu_ready, eth_wb_ack_o},
                (exp_gnt[i] == 2'b01) ? 2'b10 : 2'b01);
            chk($sformatf("rr_resp_gnt_%0d", i), gnt_o, 0);
            mem_ready = 1'b0;
            tick();
            chk($sformatf("rr_idle_gnt_%0d", i), gnt_o, 0);
        end
        cpu_valid    = 1'b0;
        eth_wb_cyc_i = 1'b0;
        eth_wb_stb_i = 1'b0;
        tick();

        // ETH read that never completes: watchdog of width 4 fires after 15 cycles
        eth_wb_adr_i = 32'h0000_0008;
        eth_wb_we_i  = 1'b0;
        eth_wb_cyc_i = 1'b1;
        eth_wb_stb_i = 1'b1;
        mem_rdata    = 32'h5555_AAAA;
        mv_cycles    = 0;
        tick();
        chk("eth_to_wstrb", mem_wstrb, 0);
        while (mem_valid && mv_cycles < 40) begin
            if (eth_wb_ack_o || eth_wb_err_o) mv_cycles = 100;
            else mv_cycles++;
            tick();
        end
        chk("eth_to_cycles", mv_cycles, 15);
        chk("eth_to_err", eth_wb_err_o, 1);
        chk("eth_to_no_ack", eth_wb_ack_o, 0);
        eth_wb_cyc_i = 1'b0;
        eth_wb_stb_i = 1'b0;
        tick();
        chk("eth_to_err_pulse", eth_wb_err_o, 0);

        // CPU read that never completes: ready with zero data
        cpu_valid   = 1'b1;
        cpu_address = 16'h0044;
        mv_cycles   = 0;
        tick();
        cpu_valid = 1'b0;
        while (mem_valid && mv_cycles < 40) begin
            mv_cycles++;
            tick();
        end
        chk("cpu_to_cycles", mv_cycles, 15);
        chk("cpu_to_ready", cpu_ready, 1);
        chk("cpu_to_rdata", cpu_rdata, 0);
        tick();

        // ETH withdraws strobe mid-access: memory completes, no ack or err
        eth_wb_adr_i = 32'h0000_0300;
        eth_wb_cyc_i = 1'b1;
        eth_wb_stb_i = 1'b1;
        tick();
        chk("eth_abort_gnt", gnt_o, 2'b10);
        eth_wb_stb_i = 1'b0;
        tick();
        chk("eth_abort_still_valid", mem_valid, 1);
        mem_ready = 1'b1;
        tick();
        chk("eth_abort_valid_drop", mem_valid, 0);
        chk("eth_abort_no_resp", {eth_wb_ack_o, eth_wb_err_o}, 0);
        mem_ready    = 1'b0;
        eth_wb_cyc_i = 1'b0;
        tick();

        // Reset in the middle of a CPU access, with mem_ready arriving afterwards
        cpu_valid   = 1'b1;
        cpu_address = 16'h0060;
        tick();
        chk("mid_rst_pre_valid", mem_valid, 1);
        cpu_valid = 1'b0;
        rst       = 1'b0;
        #1;
        chk("mid_rst_valid", mem_valid, 0);
        chk("mid_rst_gnt", gnt_o, 0);
        chk("mid_rst_addr", mem_address, 0);
        chk("mid_rst_rdata", cpu_rdata, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        tick();
        chk("mid_rst_no_ready", cpu_ready, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_ignore_ready", {cpu_ready, eth_wb_ack_o, mem_valid}, 0);
        mem_ready   = 1'b0;
        cpu_valid   = 1'b1;
        cpu_address = 16'h0080;
        tick();
        chk("post_rst_gnt", gnt_o, 2'b01);
        chk("post_rst_addr", mem_address, 16'h0080);
        cpu_valid = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        chk("post_rst_ready", cpu_ready, 1);
        chk("post_rst_rdata", cpu_rdata, 32'h1234_5678);
        mem_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // No cycle may ever show both owners.
    always @(negedge clk) begin
        if (rst && gnt_o == 2'b11) chk("gnt_onehot", gnt_o, 2'b00);
    end

endmodule
